// File: rtl/sprite_motion_ctrl.sv
// rtl/sprite_motion_ctrl.sv - per-frame position update for one sprite
//
// Computes the top-left corner of a single sprite once per video frame.
// Horizontal motion follows two player buttons with a speed ramp and
// clamps at the screen edges; vertical motion is an optional automatic
// bounce between Y_MIN and V_ACTIVE-SPR_H. Every output register loads
// only on the frame_tick edge, so the renderer never sees a change
// mid-frame.
//
// Ports:
//   clk         pixel clock
//   rst_n       asynchronous active-low reset
//   frame_tick  one-cycle pulse at start of vertical blank
//   btn_left    raw asynchronous button level
//   btn_right   raw asynchronous button level
//   auto_y      enables the vertical bounce
//   POSX        sprite left column
//   pos_y       sprite top row
//   at_left     POSX == 0
//   at_right    POSX == H_ACTIVE-SPR_W

module sprite_motion_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int SPR_W     = 40,
    parameter int SPR_H     = 24,
    parameter int X_INIT    = 300,
    parameter int Y_INIT    = 440,
    parameter int Y_MIN     = 400,
    parameter int STEP_Y    = 2,
    parameter int MAX_SPEED = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        auto_y,
    output logic [10:0] POSX,
    output logic [10:0] pos_y,
    output logic        at_left,
    output logic        at_right
);

    localparam int SPD_W = $clog2(MAX_SPEED + 1);

    localparam logic signed [11:0] X_MAX_S  = 12'(H_ACTIVE - SPR_W);
    localparam logic signed [11:0] Y_MAX_S  = 12'(V_ACTIVE - SPR_H);
    localparam logic signed [11:0] Y_MIN_S  = 12'(Y_MIN);
    localparam logic signed [11:0] STEP_Y_S = 12'(STEP_Y);
    localparam logic [SPD_W-1:0]   MAX_SPD  = SPD_W'(MAX_SPEED);

    typedef enum logic [1:0] {
        IDLE,
        MOVE_L,
        MOVE_R
    } h_state_t;

    h_state_t          state, state_n;
    logic [SPD_W-1:0]  spd, spd_n, spd_mv;
    logic [10:0]       posx, posx_n;
    logic [10:0]       posy, posy_n;
    logic              dir_y, dir_y_n;
    logic              l_meta, l, r_meta, r;
    logic signed [11:0] x_ext, x_sum, y_ext, y_sum;

    assign POSX  = posx;
    assign pos_y = posy;
    assign x_ext = signed'({1'b0, posx});
    assign y_ext = signed'({1'b0, posy});

    // Two-flop synchronizers; no debounce needed at frame-rate sampling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_meta <= 1'b0;
            l      <= 1'b0;
            r_meta <= 1'b0;
            r      <= 1'b0;
        end else begin
            l_meta <= btn_left;
            l      <= l_meta;
            r_meta <= btn_right;
            r      <= r_meta;
        end
    end

    // Horizontal FSM and arithmetic.
    always_comb begin
        state_n = state;
        spd_n   = spd;
        posx_n  = posx;
        spd_mv  = '0;
        x_sum   = x_ext;
        if (frame_tick) begin
            if (l ^ r) begin
                // Continuing in the same direction ramps; anything else
                // (idle, reversal, post-clamp) restarts at speed 1.
                if ((l && state == MOVE_L) || (r && state == MOVE_R))
                    spd_mv = (spd >= MAX_SPD) ? MAX_SPD : spd + SPD_W'(1);
                else
                    spd_mv = SPD_W'(1);
                if (l)
                    x_sum = x_ext - signed'(12'(spd_mv));
                else
                    x_sum = x_ext + signed'(12'(spd_mv));
                if (x_sum < 12'sd0) begin
                    posx_n  = 11'd0;
                    spd_n   = '0;
                    state_n = IDLE;
                end else if (x_sum > X_MAX_S) begin
                    posx_n  = X_MAX_S[10:0];
                    spd_n   = '0;
                    state_n = IDLE;
                end else begin
                    posx_n  = x_sum[10:0];
                    spd_n   = spd_mv;
                    state_n = l ? MOVE_L : MOVE_R;
                end
            end else begin
                state_n = IDLE;
                spd_n   = '0;
            end
        end
    end

    // Vertical bounce; dir_y 0 = down, 1 = up.
    always_comb begin
        posy_n  = posy;
        dir_y_n = dir_y;
        y_sum   = y_ext;
        if (frame_tick && auto_y) begin
            if (!dir_y) begin
                y_sum = y_ext + STEP_Y_S;
                if (y_sum >= Y_MAX_S) begin
                    posy_n  = Y_MAX_S[10:0];
                    dir_y_n = 1'b1;
                end else begin
                    posy_n  = y_sum[10:0];
                end
            end else begin
                y_sum = y_ext - STEP_Y_S;
                if (y_sum <= Y_MIN_S) begin
                    posy_n  = Y_MIN_S[10:0];
                    dir_y_n = 1'b0;
                end else begin
                    posy_n  = y_sum[10:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            spd      <= '0;
            posx     <= 11'(X_INIT);
            posy     <= 11'(Y_INIT);
            dir_y    <= 1'b0;
            at_left  <= 1'b0;
            at_right <= 1'b0;
        end else begin
            state <= state_n;
            spd   <= spd_n;
            posx  <= posx_n;
            posy  <= posy_n;
            dir_y <= dir_y_n;
            // Flags follow the next-state position so they change in the
            // same cycle as POSX, and only on a tick.
            if (frame_tick) begin
                at_left  <= (posx_n == 11'd0);
                at_right <= (posx_n == X_MAX_S[10:0]);
            end
        end
    end

endmodule

// File: doc/sprite_motion_ctrl.md
# sprite_motion_ctrl

- Computes the top-left position of one 40×24 sprite once per video frame.
- Feeds `POSX`/`pos_y` directly to the sprite ROM renderer. That renderer compares them against the live pixel coordinates to decide whether to paint.
- Horizontal motion comes from two player buttons and uses a speed ramp.
- Vertical motion is an optional automatic bounce.
- All outputs change only on the frame tick (start of vertical blank), so the renderer never sees a position change mid-frame.

## Interface
- `H_ACTIVE`, default 640: visible pixels per line.
- `V_ACTIVE`, default 480: visible lines per frame.
- `SPR_W`, default 40: sprite width.
- `SPR_H`, default 24: sprite height.
- `X_INIT`, default 300: reset value of `POSX`.
- `Y_INIT`, default 440: reset value of `pos_y`.
- `Y_MIN`, default 400: upper bound (smallest y) of the bounce.
- `STEP_Y`, default 2: vertical step per frame.
- `MAX_SPEED`, default 6: horizontal speed ceiling, in pixels per frame.
- `clk`, in, 1: pixel clock. One clock; reset is asynchronous and active-low.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `frame_tick`, in, 1: one-cycle pulse at start of vertical blank, from the timing generator.
- `btn_left`, in, 1: raw, asynchronous level.
- `btn_right`, in, 1: raw, asynchronous level.
- `auto_y`, in, 1: when 1, enables the vertical bounce.
- `POSX`, out, 11: sprite left column.
- `pos_y`, out, 11: sprite top row.
- `at_left`, out, 1: registered; 1 when `POSX == 0`.
- `at_right`, out, 1: registered; 1 when `POSX == H_ACTIVE-SPR_W`.

## Operation
- **Button synchronizers:**
  - Each button passes through a 2-flop synchronizer; `l`/`r` are the synchronized levels.
  - Debounce is not required, because sampling happens only at frame rate.
- **Horizontal FSM:**
  - States are IDLE, MOVE_L and MOVE_R, with a speed register `spd` of 0..`MAX_SPEED`.
  - The FSM evaluates only in cycles where `frame_tick` = 1.
  - Both or neither button pressed: state → IDLE, `spd` → 0, `POSX` holds.
  - Left only:
    - If state is MOVE_L: `spd` → min(`spd`+1, `MAX_SPEED`).
    - Otherwise: `spd` → 1 and state → MOVE_L.
    - Then `POSX` → `POSX` − new `spd`.
  - Right only: symmetric, with `POSX` → `POSX` + new `spd`.
  - Direction reversal always restarts at speed 1.
- **Horizontal arithmetic:**
  - Compute in 12-bit signed.
  - A result below 0 clamps to 0.
  - A result above `H_ACTIVE-SPR_W` (600) clamps to 600.
  - On any clamp: `spd` → 0 and state → IDLE. A still-held button restarts at speed 1 on the next tick and re-clamps; `POSX` stays at the edge.
- **Vertical bounce** (on `frame_tick` with `auto_y` = 1; direction register `dir_y`, 0 = down, 1 = up):
  - Down: `pos_y` + `STEP_Y`. If the result is ≥ `Y_MAX` = `V_ACTIVE-SPR_H` (456), set `pos_y` = 456 and `dir_y` → 1.
  - Up: `pos_y` − `STEP_Y`. If the result is ≤ `Y_MIN`, set `pos_y` = `Y_MIN` and `dir_y` → 0.
  - With `auto_y` = 0, `pos_y` and `dir_y` hold. Re-enabling resumes in the stored direction.
- **Edge flags:** `at_left`/`at_right` are registered from the next-state `POSX`, so they update in the same cycle as `POSX`.

## Timing
- **Reset values** (while `rst_n` = 0, immediately, asynchronously):
  - `POSX` = `X_INIT` (300), `pos_y` = `Y_INIT` (440).
  - `at_left` = 0, `at_right` = 0.
  - FSM = IDLE, `spd` = 0, `dir_y` = 0, synchronizers = 0.
- **Update latency:**
  - Registers load on the rising edge where `frame_tick` = 1.
  - New values are visible from the following cycle.
  - Outputs are constant for all other cycles.
- **Button latency:** a button level must be stable at least 2 cycles before the `frame_tick` edge to be seen at that tick.
- **Back-to-back ticks:** consecutive-cycle `frame_tick` pulses are legal, and each one is a full update.
- **Reset mid-frame:** reset forces the values above. The first tick after release behaves as if coming from IDLE.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-frame with `POSX` = 120 → same cycle `POSX` = 300, `pos_y` = 440, both flags 0. After release, with no buttons, 3 ticks → values unchanged.
- **Right ramp:** hold `btn_right`, issue 4 ticks from 300 → `POSX` 301, 303, 306, 310. Release, 1 tick → 310, FSM IDLE.
- **Speed cap and right clamp:** hold right from `POSX` = 580 with `spd` already at 6 → 586, 592, 598, then 600 with `at_right` = 1 and `spd` = 0. The next tick gives 600 again.
- **Left clamp and reversal:** from `POSX` = 5, hold left → 4, 2, then 0 with `at_left` = 1. Switch to right → 1, 3 (speed restarts at 1).
- **Both buttons and sync latency:** both buttons held, 2 ticks → `POSX` unchanged. Pressing right 1 cycle before a tick → no move at that tick; a move occurs at the next tick.
- **Bounce:** `auto_y` = 1 from 440 → 442 … 456 after 8 ticks, then 454, 452. Drop `auto_y` at 452 → holds. Re-enable → 450.
